// File: rtl/vx_div_unit_pkg.sv
// Shared op codes, writeback encodings and FSM state type for the divide unit.
package vx_div_unit_pkg;

  localparam logic [4:0] ALU_DIV  = 5'h14;
  localparam logic [4:0] ALU_DIVU = 5'h15;
  localparam logic [4:0] ALU_REM  = 5'h16;
  localparam logic [4:0] ALU_REMU = 5'h17;

  localparam logic [1:0] NO_WB = 2'b00;

  localparam logic [5:0] DIV_LAST_STEP = 6'd31;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_e;

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  function automatic logic is_signed_op(input logic [4:0] op);
    return (op == ALU_DIV) || (op == ALU_REM);
  endfunction

  function automatic logic is_rem_op(input logic [4:0] op);
    return (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/vx_div_lane.sv
// One thread lane: radix-2 restoring divider with sign, zero and overflow fix-up.
module vx_div_lane
  import vx_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        is_signed,
  input  logic        is_rem,
  input  logic        active,
  output logic [31:0] result
);

  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] dvs_q;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic        signed_q;
  logic        rem_sel_q;
  logic        active_q;

  logic [32:0] shifted;
  logic [32:0] trial;

  // Partial remainder with the next dividend bit shifted in, and the trial subtraction.
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    trial   = shifted - {1'b0, dvs_q};
  end

  // Operand capture on load; one restoring step per enable.
  // quo_q starts as |dividend| and is shifted out MSB-first while quotient bits enter at the LSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      signed_q  <= 1'b0;
      rem_sel_q <= 1'b0;
      active_q  <= 1'b0;
    end else if (load) begin
      a_q       <= a;
      b_q       <= b;
      dvs_q     <= (is_signed && b[31]) ? (32'd0 - b) : b;
      quo_q     <= (is_signed && a[31]) ? (32'd0 - a) : a;
      rem_q     <= '0;
      signed_q  <= is_signed;
      rem_sel_q <= is_rem;
      active_q  <= active;
    end else if (step) begin
      if (!trial[32]) begin
        rem_q <= trial[31:0];
        quo_q <= {quo_q[30:0], 1'b1};
      end else begin
        rem_q <= shifted[31:0];
        quo_q <= {quo_q[30:0], 1'b0};
      end
    end
  end

  logic [31:0] q_fix;
  logic [31:0] r_fix;

  // Sign restoration, then divide-by-zero and signed-overflow overrides.
  always_comb begin
    q_fix = (signed_q && (a_q[31] ^ b_q[31])) ? (32'd0 - quo_q) : quo_q;
    r_fix = (signed_q && a_q[31]) ? (32'd0 - rem_q) : rem_q;
    if (b_q == '0) begin
      q_fix = '1;
      r_fix = a_q;
    end else if (signed_q && (a_q == 32'h8000_0000) && (b_q == '1)) begin
      q_fix = 32'h8000_0000;
      r_fix = '0;
    end
    result = '0;
    if (active_q) begin
      result = rem_sel_q ? r_fix : q_fix;
    end
  end

endmodule

// File: rtl/vx_div_unit.sv
// Multi-cycle DIV/DIVU/REM/REMU unit: freezes the decode/execute register,
// runs 32 restoring steps on every lane, then emits a single result beat.
module vx_div_unit
  import vx_div_unit_pkg::*;
#(
  parameter  int unsigned NT   = 4,
  parameter  int unsigned NW   = 8,
  localparam int unsigned NW_W = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        in_alu_op,
  input  logic [NT*32-1:0]  in_a_reg_data,
  input  logic [NT*32-1:0]  in_b_reg_data,
  input  logic [NT-1:0]     in_valid,
  input  logic [4:0]        in_rd,
  input  logic [1:0]        in_wb,
  input  logic [NW_W-1:0]   in_warp_num,
  output logic              out_freeze,
  output logic              out_busy,
  output logic              out_result_valid,
  output logic [NT*32-1:0]  out_result,
  output logic [4:0]        out_rd,
  output logic [1:0]        out_wb,
  output logic [NT-1:0]     out_valid,
  output logic [NW_W-1:0]   out_warp_num
);

  div_state_e state_q;
  div_state_e state_n;

  logic [5:0]       cnt_q;
  logic [4:0]       rd_q;
  logic [1:0]       wb_q;
  logic [NT-1:0]    valid_q;
  logic [NW_W-1:0]  warp_q;

  logic             div_class;
  logic             accept;
  logic             step;
  logic             done;
  logic [NT*32-1:0] lane_result;

  // Current state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DIV_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Next-state logic, freeze/busy/strobe decode.
  // Freeze is gated by reset so every output reads 0 while reset is held.
  always_comb begin
    div_class = is_div_op(in_alu_op) && (|in_valid);
    state_n   = state_q;
    accept    = 1'b0;
    step      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      DIV_IDLE: begin
        if (div_class) begin
          accept  = 1'b1;
          state_n = DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        step = 1'b1;
        if (cnt_q == DIV_LAST_STEP) begin
          state_n = DIV_DONE;
        end
      end
      DIV_DONE: begin
        done    = 1'b1;
        state_n = DIV_IDLE;
      end
      default: state_n = DIV_IDLE;
    endcase
    out_freeze       = !reset && (accept || step);
    out_busy         = step;
    out_result_valid = done;
  end

  // Step counter and writeback tag latches.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      rd_q    <= '0;
      wb_q    <= NO_WB;
      valid_q <= '0;
      warp_q  <= '0;
    end else if (accept) begin
      cnt_q   <= '0;
      rd_q    <= in_rd;
      wb_q    <= in_wb;
      valid_q <= in_valid;
      warp_q  <= in_warp_num;
    end else if (step) begin
      cnt_q <= cnt_q + 6'd1;
    end
  end

  for (genvar i = 0; i < NT; i++) begin : g_lane
    vx_div_lane u_lane (
      .clk       (clk),
      .reset     (reset),
      .load      (accept),
      .step      (step),
      .a         (in_a_reg_data[32*i +: 32]),
      .b         (in_b_reg_data[32*i +: 32]),
      .is_signed (is_signed_op(in_alu_op)),
      .is_rem    (is_rem_op(in_alu_op)),
      .active    (in_valid[i]),
      .result    (lane_result[32*i +: 32])
    );
  end

  // Result beat outputs are held at zero outside the DONE cycle.
  always_comb begin
    out_result   = '0;
    out_rd       = '0;
    out_wb       = NO_WB;
    out_valid    = '0;
    out_warp_num = '0;
    if (done) begin
      out_result   = lane_result;
      out_rd       = rd_q;
      out_wb       = wb_q;
      out_valid    = valid_q;
      out_warp_num = warp_q;
    end
  end

endmodule

// File: tb/tb_vx_div_unit.sv
// Scoreboard bench for vx_div_unit: directed vectors with hand-computed results.
module tb_vx_div_unit;
  import vx_div_unit_pkg::*;

  localparam int NT   = 4;
  localparam int NW   = 8;
  localparam int NW_W = 3;
  localparam logic [4:0] OP_ADD = 5'h00;

  logic              clk;
  logic              reset;
  logic [4:0]        in_alu_op;
  logic [NT*32-1:0]  in_a_reg_data;
  logic [NT*32-1:0]  in_b_reg_data;
  logic [NT-1:0]     in_valid;
  logic [4:0]        in_rd;
  logic [1:0]        in_wb;
  logic [NW_W-1:0]   in_warp_num;
  logic              out_freeze;
  logic              out_busy;
  logic              out_result_valid;
  logic [NT*32-1:0]  out_result;
  logic [4:0]        out_rd;
  logic [1:0]        out_wb;
  logic [NT-1:0]     out_valid;
  logic [NW_W-1:0]   out_warp_num;

  vx_div_unit #(.NT(NT), .NW(NW)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_alu_op        (in_alu_op),
    .in_a_reg_data    (in_a_reg_data),
    .in_b_reg_data    (in_b_reg_data),
    .in_valid         (in_valid),
    .in_rd            (in_rd),
    .in_wb            (in_wb),
    .in_warp_num      (in_warp_num),
    .out_freeze       (out_freeze),
    .out_busy         (out_busy),
    .out_result_valid (out_result_valid),
    .out_result       (out_result),
    .out_rd           (out_rd),
    .out_wb           (out_wb),
    .out_valid        (out_valid),
    .out_warp_num     (out_warp_num)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NT*32-1:0] result;
    logic [4:0]       rd;
    logic [1:0]       wb;
    logic [NT-1:0]    valid;
    logic [NW_W-1:0]  warp;
    int               cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NT*32-1:0] pk(input logic [31:0] l0, input logic [31:0] l1,
                                          input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  // Monitor: pops the scoreboard on every result beat, checks idle outputs otherwise.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_result_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got result beat %0h expected none", out_result);
        end else begin
          exp_t e;
          e = sb.pop_front();
          for (int i = 0; i < NT; i++)
            check($sformatf("lane%0d_result", i), 128'(out_result[32*i +: 32]), 128'(e.result[32*i +: 32]));
          check("out_rd", 128'(out_rd), 128'(e.rd));
          check("out_wb", 128'(out_wb), 128'(e.wb));
          check("out_valid", 128'(out_valid), 128'(e.valid));
          check("out_warp_num", 128'(out_warp_num), 128'(e.warp));
          check("latency", 128'(cyc - e.cyc), 128'(33));
        end
      end else begin
        check("idle_outputs_zero", 128'({out_result, out_rd, out_wb, out_valid, out_warp_num}), 128'(0));
      end
    end
  end

  task automatic drive(input logic [4:0] op, input logic [NT*32-1:0] a, input logic [NT*32-1:0] b,
                       input logic [NT-1:0] v, input logic [4:0] rd, input logic [1:0] wb,
                       input logic [NW_W-1:0] warp);
    in_alu_op     = op;
    in_a_reg_data = a;
    in_b_reg_data = b;
    in_valid      = v;
    in_rd         = rd;
    in_wb         = wb;
    in_warp_num   = warp;
  endtask

  task automatic idle_inputs();
    @(posedge clk); #1;
    drive(OP_ADD, '0, '0, '0, '0, '0, '0);
  endtask

  // Presents a div op, holds it while frozen (as the pipeline register would) and
  // records the expected beat. Returns during the result cycle.
  task automatic issue(input logic [4:0] op, input logic [NT*32-1:0] a, input logic [NT*32-1:0] b,
                       input logic [NT-1:0] v, input logic [4:0] rd, input logic [1:0] wb,
                       input logic [NW_W-1:0] warp, input logic [NT*32-1:0] exp_res);
    int fc;
    int bc;
    exp_t e;
    @(posedge clk); #1;
    drive(op, a, b, v, rd, wb, warp);
    e.result = exp_res; e.rd = rd; e.wb = wb; e.valid = v; e.warp = warp; e.cyc = cyc;
    sb.push_back(e);
    fc = 0;
    bc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!out_freeze) break;
      fc++;
      if (out_busy) bc++;
    end
    check("freeze_cycles", 128'(fc), 128'(33));
    check("busy_cycles", 128'(bc), 128'(32));
  endtask

  initial begin
    int fc;
    reset = 1'b1;
    drive(OP_ADD, '0, '0, '0, '0, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 128'({out_freeze, out_busy, out_result_valid, out_result, out_rd,
                                  out_wb, out_valid, out_warp_num}), 128'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    // DIVU across all lanes.
    issue(ALU_DIVU, pk(100, 7, 32'hFFFF_FFFF, 5), pk(7, 7, 1, 10), 4'hF, 5'd3, 2'd1, 3'd2,
          pk(14, 1, 32'hFFFF_FFFF, 0));
    // Back-to-back signed DIV: -7/2, 7/-2, 42/0, overflow.
    issue(ALU_DIV, pk(32'hFFFF_FFF9, 7, 42, 32'h8000_0000), pk(2, 32'hFFFF_FFFE, 0, 32'hFFFF_FFFF),
          4'hF, 5'd10, 2'd1, 3'd1, pk(32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000));
    // Same operands as REM.
    issue(ALU_REM, pk(32'hFFFF_FFF9, 7, 42, 32'h8000_0000), pk(2, 32'hFFFF_FFFE, 0, 32'hFFFF_FFFF),
          4'hF, 5'd11, 2'd2, 3'd4, pk(32'hFFFF_FFFF, 1, 42, 0));
    // REMU including divide by zero.
    issue(ALU_REMU, pk(42, 100, 32'hFFFF_FFFF, 0), pk(0, 7, 10, 5), 4'hF, 5'd12, 2'd3, 3'd7,
          pk(42, 2, 5, 0));
    idle_inputs();
    repeat (3) @(posedge clk);

    // Partial lane mask: inactive lanes read 0.
    issue(ALU_DIVU, pk(20, 9, 30, 11), pk(4, 3, 5, 2), 4'b0101, 5'd5, 2'd2, 3'd3,
          pk(5, 0, 6, 0));
    // Signed DIV with negative divisor and zero divisors.
    issue(ALU_DIV, pk(32'hFFFF_FF9C, 32'hFFFF_FF9C, 0, 32'hFFFF_FFFF), pk(32'hFFFF_FFF9, 7, 0, 0),
          4'hF, 5'd31, 2'd1, 3'd0, pk(14, 32'hFFFF_FFF2, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
    idle_inputs();

    // Non-div op and div with no active lanes: no freeze, no beat.
    fc = 0;
    drive(OP_ADD, pk(1, 2, 3, 4), pk(1, 1, 1, 1), 4'hF, 5'd1, 2'd1, 3'd1);
    repeat (20) begin @(negedge clk); if (out_freeze) fc++; end
    drive(ALU_DIV, pk(1, 2, 3, 4), pk(1, 1, 1, 1), 4'h0, 5'd1, 2'd1, 3'd1);
    repeat (40) begin @(negedge clk); if (out_freeze) fc++; end
    check("no_freeze_non_div", 128'(fc), 128'(0));

    // Reset at BUSY cycle 10 abandons the op.
    @(posedge clk); #1;
    drive(ALU_DIV, pk(100, 100, 100, 100), pk(3, 3, 3, 3), 4'hF, 5'd7, 2'd1, 3'd6);
    repeat (10) @(posedge clk);
    #1;
    @(negedge clk);
    check("busy_before_reset", 128'(out_busy), 128'(1));
    @(posedge clk); #1;
    reset = 1'b1;
    drive(OP_ADD, '0, '0, '0, '0, '0, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("after_abort_outputs", 128'({out_freeze, out_busy, out_result_valid, out_result, out_rd,
                                        out_wb, out_valid, out_warp_num}), 128'(0));
    repeat (40) @(posedge clk);

    // Fresh op after the abort.
    issue(ALU_DIVU, pk(1000, 33, 64, 9), pk(10, 4, 8, 3), 4'hF, 5'd9, 2'd1, 3'd5,
          pk(100, 8, 8, 3));
    idle_inputs();

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    check("scoreboard_drained", 128'(sb.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
